// File: rtl/fpga_rst_seq_pkg.sv
// fpga_rst_seq_pkg: shared state encoding and counter sizing helpers for the reset sequencer.
package fpga_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_DRAM_RST   = 3'd1,
    ST_WAIT_CALIB = 3'd2,
    ST_SOC_HOLD   = 3'd3,
    ST_RUN        = 3'd4,
    ST_ERROR      = 3'd5
  } state_e;

  localparam logic [7:0] RstCntMax = 8'hff;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync.sv
// sync: two-flop synchroniser for a single asynchronous level input.
module sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d_i;
      r_q    <= r_meta;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: board reset sequencer -- clock lock, DRAM reset and calibration, then SoC release.
// All outputs are registered from the next state so they move together with state_o.
module fpga_rst_seq
  import fpga_rst_seq_pkg::*;
#(
  parameter int DramRstCycles = 64,
  parameter int MinRstCycles  = 16,
  parameter int CalibTimeout  = 2**20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clk_locked_i,
  input  logic       calib_done_i,
  input  logic       calib_bypass_i,
  input  logic [1:0] boot_mode_i,
  input  logic       sw_rst_req_i,
  output logic       soc_rst_no,
  output logic       dram_rst_o,
  output logic [1:0] boot_mode_o,
  output logic [2:0] state_o,
  output logic       calib_err_o,
  output logic [7:0] rst_cnt_o
);

  localparam int CW = cnt_width(max3(DramRstCycles, MinRstCycles, CalibTimeout));
  localparam logic [CW-1:0] DramLast  = CW'(DramRstCycles - 1);
  localparam logic [CW-1:0] HoldLast  = CW'(MinRstCycles - 1);
  localparam logic [CW-1:0] CalibLast = CW'(CalibTimeout - 1);
  localparam logic [CW-1:0] CntSat    = {CW{1'b1}};

  state_e          r_state;
  state_e          w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_sw_q;
  logic            r_soc_rst_n;
  logic            r_dram_rst;
  logic [1:0]      r_boot_mode;
  logic            r_calib_err;
  logic [7:0]      r_rst_cnt;
  logic            w_lock;
  logic            w_calib_s;
  logic            w_calib;
  logic            w_sw_rise;
  logic            w_entry;

  sync u_sync_lock (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (clk_locked_i),
    .q_o   (w_lock)
  );

  sync u_sync_calib (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (calib_done_i),
    .q_o   (w_calib_s)
  );

  assign w_calib   = w_calib_s | calib_bypass_i;
  assign w_sw_rise = sw_rst_req_i & ~r_sw_q;
  assign w_entry   = (w_next != r_state);

  // Lock loss overrides every other transition, including a coincident soft reset.
  always_comb begin
    w_next = r_state;
    if (r_state != ST_WAIT_LOCK && !w_lock) begin
      w_next = ST_WAIT_LOCK;
    end else begin
      unique case (r_state)
        ST_WAIT_LOCK:  w_next = w_lock ? ST_DRAM_RST : ST_WAIT_LOCK;
        ST_DRAM_RST:   w_next = (r_cnt == DramLast) ? ST_WAIT_CALIB : ST_DRAM_RST;
        ST_WAIT_CALIB: w_next = w_calib ? ST_SOC_HOLD :
                                (r_cnt == CalibLast) ? ST_ERROR : ST_WAIT_CALIB;
        ST_SOC_HOLD:   w_next = (r_cnt == HoldLast) ? ST_RUN : ST_SOC_HOLD;
        ST_RUN:        w_next = w_sw_rise ? ST_SOC_HOLD : ST_RUN;
        ST_ERROR:      w_next = w_sw_rise ? ST_DRAM_RST : ST_ERROR;
        default:       w_next = ST_WAIT_LOCK;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_WAIT_LOCK;
      r_cnt       <= '0;
      r_sw_q      <= 1'b0;
      r_soc_rst_n <= 1'b0;
      r_dram_rst  <= 1'b1;
      r_boot_mode <= 2'd0;
      r_calib_err <= 1'b0;
      r_rst_cnt   <= 8'd0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_entry ? '0 : (r_cnt == CntSat) ? r_cnt : r_cnt + 1'b1;
      r_sw_q      <= sw_rst_req_i;
      r_soc_rst_n <= (w_next == ST_RUN);
      r_dram_rst  <= (w_next == ST_WAIT_LOCK) || (w_next == ST_DRAM_RST);
      if (w_entry && w_next == ST_SOC_HOLD)
        r_boot_mode <= boot_mode_i;
      if (w_next == ST_ERROR)
        r_calib_err <= 1'b1;
      if (r_state == ST_RUN && w_next == ST_SOC_HOLD && r_rst_cnt != RstCntMax)
        r_rst_cnt <= r_rst_cnt + 8'd1;
    end
  end

  assign state_o     = r_state;
  assign soc_rst_no  = r_soc_rst_n;
  assign dram_rst_o  = r_dram_rst;
  assign boot_mode_o = r_boot_mode;
  assign calib_err_o = r_calib_err;
  assign rst_cnt_o   = r_rst_cnt;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb_fpga_rst_seq: directed bench for the reset sequencer with hand-computed cycle timing.
module tb_fpga_rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b0;
  logic       calib = 1'b0;
  logic       byp = 1'b0;
  logic [1:0] bm = 2'd0;
  logic       sw = 1'b0;
  logic       soc_rst_n;
  logic       dram_rst;
  logic [1:0] boot_o;
  logic [2:0] state;
  logic       calib_err;
  logic [7:0] rst_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  fpga_rst_seq #(
    .DramRstCycles (4),
    .MinRstCycles  (3),
    .CalibTimeout  (100)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .clk_locked_i   (lock),
    .calib_done_i   (calib),
    .calib_bypass_i (byp),
    .boot_mode_i    (bm),
    .sw_rst_req_i   (sw),
    .soc_rst_no     (soc_rst_n),
    .dram_rst_o     (dram_rst),
    .boot_mode_o    (boot_o),
    .state_o        (state),
    .calib_err_o    (calib_err),
    .rst_cnt_o      (rst_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_soc"}, 32'(soc_rst_n), 0);
    chk({tag, "_dram"}, 32'(dram_rst), 1);
    chk({tag, "_boot"}, 32'(boot_o), 0);
    chk({tag, "_err"}, 32'(calib_err), 0);
    chk({tag, "_cnt"}, 32'(rst_cnt), 0);
  endtask

  initial begin
    tick(3);
    chk_rst_vals("reset");
    rst = 1'b0;
    tick(2);
    chk("wait_lock_state", 32'(state), 0);
    lock = 1'b1;
    tick(2);
    chk("lock_sync_state", 32'(state), 0);
    tick(1);
    chk("dram_entry_state", 32'(state), 1);
    chk("dram_entry_rst", 32'(dram_rst), 1);
    tick(3);
    chk("dram_last_state", 32'(state), 1);
    chk("dram_last_rst", 32'(dram_rst), 1);
    tick(1);
    chk("calib_entry_state", 32'(state), 2);
    chk("calib_entry_dram", 32'(dram_rst), 0);
    tick(5);
    chk("calib_wait_state", 32'(state), 2);
    calib = 1'b1;
    bm = 2'd2;
    tick(2);
    chk("calib_sync_state", 32'(state), 2);
    tick(1);
    chk("hold_entry_state", 32'(state), 3);
    chk("hold_entry_boot", 32'(boot_o), 2);
    chk("hold_entry_soc", 32'(soc_rst_n), 0);
    tick(1);
    bm = 2'd3;
    tick(1);
    chk("hold_last_soc", 32'(soc_rst_n), 0);
    tick(1);
    chk("run_state", 32'(state), 4);
    chk("run_soc", 32'(soc_rst_n), 1);
    chk("run_boot_stable", 32'(boot_o), 2);
    sw = 1'b1;
    bm = 2'd1;
    tick(1);
    chk("soft_state", 32'(state), 3);
    chk("soft_soc", 32'(soc_rst_n), 0);
    chk("soft_dram", 32'(dram_rst), 0);
    chk("soft_boot", 32'(boot_o), 1);
    chk("soft_cnt", 32'(rst_cnt), 1);
    sw = 1'b0;
    tick(2);
    chk("soft_hold_soc", 32'(soc_rst_n), 0);
    tick(1);
    chk("soft_run_soc", 32'(soc_rst_n), 1);
    lock = 1'b0;
    tick(2);
    chk("lock_drop_sync_state", 32'(state), 4);
    sw = 1'b1;
    tick(1);
    chk("lockloss_state", 32'(state), 0);
    chk("lockloss_soc", 32'(soc_rst_n), 0);
    chk("lockloss_dram", 32'(dram_rst), 1);
    chk("lockloss_cnt", 32'(rst_cnt), 1);
    sw = 1'b0;
    lock = 1'b1;
    calib = 1'b0;
    tick(3);
    chk("relock_state", 32'(state), 1);
    tick(4);
    chk("to_calib_state", 32'(state), 2);
    tick(99);
    chk("timeout_last_state", 32'(state), 2);
    chk("timeout_last_err", 32'(calib_err), 0);
    tick(1);
    chk("error_state", 32'(state), 5);
    chk("error_err", 32'(calib_err), 1);
    chk("error_soc", 32'(soc_rst_n), 0);
    sw = 1'b1;
    tick(1);
    chk("retry_state", 32'(state), 1);
    chk("retry_dram", 32'(dram_rst), 1);
    chk("retry_err_sticky", 32'(calib_err), 1);
    sw = 1'b0;
    tick(1);
    chk("mid_dram_state", 32'(state), 1);
    rst = 1'b1;
    #1;
    chk_rst_vals("async_rst");
    tick(1);
    rst = 1'b0;
    byp = 1'b1;
    bm = 2'd3;
    tick(2);
    chk("restart_state", 32'(state), 0);
    tick(1);
    chk("restart_dram_state", 32'(state), 1);
    tick(4);
    chk("bypass_calib_state", 32'(state), 2);
    tick(1);
    chk("bypass_hold_state", 32'(state), 3);
    chk("bypass_boot", 32'(boot_o), 3);
    tick(3);
    chk("bypass_run_soc", 32'(soc_rst_n), 1);
    for (int i = 0; i < 255; i++) begin
      sw = 1'b1;
      tick(1);
      sw = 1'b0;
      tick(3);
    end
    chk("sat_run_state", 32'(state), 4);
    chk("sat_cnt_255", 32'(rst_cnt), 255);
    sw = 1'b1;
    tick(1);
    chk("sat_extra_state", 32'(state), 3);
    chk("sat_cnt_hold", 32'(rst_cnt), 255);
    sw = 1'b0;
    tick(3);
    chk("sat_final_state", 32'(state), 4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
